// File: rtl/cpu_mult_pkg.sv
// Shared encodings and helpers for the iterative CPU multiplier.
package cpu_mult_pkg;

  localparam logic [1:0] ModeMul    = 2'b00;
  localparam logic [1:0] ModeMulxss = 2'b01;
  localparam logic [1:0] ModeMulxsu = 2'b10;
  localparam logic [1:0] ModeMulxuu = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StFix,
    StDone
  } mult_state_e;

  function automatic int unsigned calc_nlimb(input int unsigned data_w,
                                             input int unsigned part_w);
    return data_w / part_w;
  endfunction

endpackage

// File: rtl/cpu_mult_limb.sv
// Unsigned PART_W x PART_W limb multiplier, intended to map onto a single DSP block.
module cpu_mult_limb #(
  parameter int unsigned PART_W = 16
) (
  input  logic [PART_W-1:0]   a,
  input  logic [PART_W-1:0]   b,
  output logic [2*PART_W-1:0] p
);

  assign p = {{PART_W{1'b0}}, a} * {{PART_W{1'b0}}, b};

endmodule

// File: rtl/cpu_mult_iter.sv
// Iterative DATA_W x DATA_W multiplier: one limb product per cycle on magnitudes,
// sign restored at the end, low or high word returned behind a valid/ready handshake.
module cpu_mult_iter
  import cpu_mult_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PART_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int unsigned NLIMB = calc_nlimb(DATA_W, PART_W);
  localparam int unsigned NPROD = NLIMB * NLIMB;
  localparam int unsigned CNT_W = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int unsigned ACC_W = 2 * DATA_W;

  if (DATA_W % PART_W != 0) begin : gen_bad_part
    $error("DATA_W must be a multiple of PART_W");
  end

  mult_state_e       state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              neg_q;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  acc_q;

  logic              sign1, sign2;
  logic [DATA_W-1:0] abs1, abs2;
  int unsigned       li, lj;
  logic [PART_W-1:0] a_limb, b_limb;
  logic [2*PART_W-1:0] limb_prod;
  logic [ACC_W-1:0]  addend, fix_p;

  // Only the signed-by-mode operands contribute a sign; MUL is treated as unsigned.
  always_comb begin
    sign1 = ((in_mode == ModeMulxss) || (in_mode == ModeMulxsu)) && in_src1[DATA_W-1];
    sign2 = (in_mode == ModeMulxss) && in_src2[DATA_W-1];
    abs1  = sign1 ? (~in_src1 + DATA_W'(1)) : in_src1;
    abs2  = sign2 ? (~in_src2 + DATA_W'(1)) : in_src2;
  end

  always_comb begin
    li     = 32'(cnt_q) / NLIMB;
    lj     = 32'(cnt_q) % NLIMB;
    a_limb = PART_W'(a_q >> (li * PART_W));
    b_limb = PART_W'(b_q >> (lj * PART_W));
  end

  cpu_mult_limb #(
    .PART_W(PART_W)
  ) u_limb (
    .a(a_limb),
    .b(b_limb),
    .p(limb_prod)
  );

  assign addend   = ACC_W'(limb_prod) << (PART_W * (li + lj));
  assign fix_p    = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
  assign in_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      out_valid  <= 1'b0;
      out_result <= '0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      mode_q     <= ModeMul;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= abs1;
            b_q     <= abs2;
            neg_q   <= sign1 ^ sign2;
            mode_q  <= in_mode;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= StMul;
          end
        end
        StMul: begin
          acc_q <= acc_q + addend;
          if (cnt_q == CNT_W'(NPROD - 1)) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          out_result <= (mode_q == ModeMul) ? fix_p[DATA_W-1:0] : fix_p[ACC_W-1:DATA_W];
          out_valid  <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mult_iter.sv
// Directed bench for cpu_mult_iter: default 32/16 build plus 16/8 and 32/32 builds.
module tb_cpu_mult_iter;
  import cpu_mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_src1, in_src2, out_result;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [1:0]  s_in_mode;
  logic [15:0] s_in_src1, s_in_src2, s_out_result;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [1:0]  w_in_mode;
  logic [31:0] w_in_src1, w_in_src2, w_out_result;

  cpu_mult_iter dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  cpu_mult_iter #(.DATA_W(16), .PART_W(8)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
    .in_src1(s_in_src1), .in_src2(s_in_src2),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result)
  );

  cpu_mult_iter #(.DATA_W(32), .PART_W(32)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
    .in_src1(w_in_src1), .in_src2(w_in_src2),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] x, y, p;
    x = ((m == ModeMulxss) || (m == ModeMulxsu)) ? {{32{a[31]}}, a} : {32'h0, a};
    y = (m == ModeMulxss) ? {{32{b[31]}}, b} : {32'h0, b};
    p = x * y;
    return (m == ModeMul) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op on the default build, expect 5-cycle latency, hold the result 'hold' cycles.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_src1  = a;
    in_src2  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd5);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check({tag, " result"}, 64'(out_result), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back idle"}, 64'(in_ready), 64'd1);
  endtask

  int lat;
  int pulses;
  logic [1:0]  rm;
  logic [31:0] ra, rb;

  function automatic logic [31:0] pick_operand(input int unsigned sel);
    unique case (sel)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_mode = ModeMul; in_src1 = '0; in_src2 = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_mode = ModeMul; s_in_src1 = '0; s_in_src2 = '0; s_out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_mode = ModeMul; w_in_src1 = '0; w_in_src2 = '0; w_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_result", 64'(out_result), 64'd0);

    run_op("mul basic", ModeMul, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0);
    run_op("xss minneg sq", ModeMulxss, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("xss -2*3", ModeMulxss, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 0);
    run_op("xsu ones", ModeMulxsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("xuu ones", ModeMulxuu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mul ones", ModeMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("xss minneg*max", ModeMulxss, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 0);
    run_op("xuu 2^31*2", ModeMulxuu, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 0);

    // Backpressure: result held, new requests ignored.
    in_valid = 1'b1; in_mode = ModeMul; in_src1 = 32'd3; in_src2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd5);
    in_valid = 1'b1; in_mode = ModeMulxuu; in_src1 = 32'h55; in_src2 = 32'h77;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp out_result", 64'(out_result), 64'd12);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp drained out_valid", 64'(out_valid), 64'd0);
    check("bp drained in_ready", 64'(in_ready), 64'd1);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("bp no ghost op", 64'(pulses), 64'd0);

    // Reset two cycles into MUL discards the operation.
    in_valid = 1'b1; in_mode = ModeMulxuu; in_src1 = 32'h1234_5678; in_src2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("midrst no pulse", 64'(pulses), 64'd0);
    run_op("post rst 7*6", ModeMul, 32'd7, 32'd6, 32'd42, 0);

    // 16/8 build.
    check("s in_ready", 64'(s_in_ready), 64'd1);
    s_in_valid = 1'b1; s_in_mode = ModeMul; s_in_src1 = 16'h00FF; s_in_src2 = 16'h00FF;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s latency", 64'(lat), 64'd5);
    check("s result", 64'(s_out_result), 64'hFE01);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check("s back idle", 64'(s_in_ready), 64'd1);

    // 32/32 build: single limb product.
    check("w in_ready", 64'(w_in_ready), 64'd1);
    w_in_valid = 1'b1; w_in_mode = ModeMulxuu; w_in_src1 = 32'hFFFF_FFFF;
    w_in_src2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w latency", 64'(lat), 64'd2);
    check("w result", 64'(w_out_result), 64'hFFFF_FFFE);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    check("w back idle", 64'(w_in_ready), 64'd1);

    // Mixed operands against the sign-extended reference product.
    for (int k = 0; k < 24; k++) begin
      rm = 2'($urandom_range(0, 3));
      ra = pick_operand($urandom_range(0, 5));
      rb = pick_operand($urandom_range(0, 5));
      run_op($sformatf("rand%0d m%0d %h*%h", k, rm, ra, rb), rm, ra, rb, model(rm, ra, rb),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
